// File: rtl/mult_pkg.sv
// Shared constants, parameter defaults and the radix-4 Booth digit type for
// the pipelined signed multiplier.
package mult_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    localparam int WIDTH_DEF    = 16;
    localparam int STAGES_DEF   = 2;
    localparam int APPROX_K_DEF = 4;
    localparam int TAG_W_DEF    = 4;

    // Radix-4 Booth digit, range -2..+2
    typedef logic signed [2:0] booth_digit_t;

    // Recode one overlapping triplet {y[2i+1], y[2i], y[2i-1]} into a digit
    function automatic booth_digit_t booth_encode(input logic [2:0] trip);
        booth_digit_t d;
        case (trip)
            3'b001, 3'b010: d = 3'sd1;
            3'b011:         d = 3'sd2;
            3'b100:         d = -3'sd2;
            3'b101, 3'b110: d = -3'sd1;
            default:        d = 3'sd0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_r4_mult.sv
// Combinational radix-4 Booth multiplier; approximate mode zeroes the lowest
// APPROX_K/2 digits, which removes sext(y[APPROX_K-1:0]) from the multiplier.
module booth_r4_mult
    import mult_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int APPROX_K = APPROX_K_DEF
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               approx,
    output logic [2*WIDTH-1:0] p
);

    localparam int NDIG = WIDTH / 2;
    localparam int KDIG = APPROX_K / 2;

    logic [WIDTH:0]            y_ext;
    logic signed [2*WIDTH-1:0] x_ext;
    booth_digit_t              digit [NDIG];
    logic signed [2*WIDTH-1:0] pp;
    logic signed [2*WIDTH-1:0] acc;

    assign y_ext = {y, 1'b0};
    assign x_ext = {{WIDTH{x[WIDTH-1]}}, x};

    always_comb begin
        for (int i = 0; i < NDIG; i++) begin
            digit[i] = booth_encode(y_ext[2*i +: 3]);
            if (approx && (i < KDIG)) begin
                digit[i] = 3'sd0;
            end
        end
    end

    // Sign-extended partial products summed at their radix-4 weights
    always_comb begin
        acc = '0;
        pp  = '0;
        for (int i = 0; i < NDIG; i++) begin
            case (digit[i])
                3'sd1:   pp = x_ext;
                3'sd2:   pp = x_ext <<< 1;
                -3'sd1:  pp = -x_ext;
                -3'sd2:  pp = -(x_ext <<< 1);
                default: pp = '0;
            endcase
            acc = acc + (pp <<< (2*i));
        end
    end

    assign p = acc;

endmodule

// File: rtl/mult_pipe_top.sv
// Valid/ready pipelined signed multiplier: stage 1 holds operands, stage 2 the
// product, later stages delay only. Each stage advances when empty or drained.
module mult_pipe_top
    import mult_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int STAGES   = STAGES_DEF,
    parameter int APPROX_K = APPROX_K_DEF,
    parameter int TAG_W    = TAG_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   x,
    input  logic [WIDTH-1:0]   y,
    input  logic               in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] p_out,
    output logic               out_mode,
    output logic [TAG_W-1:0]   out_tag
);

    if ((WIDTH % 2 != 0) || (WIDTH < 8) || (WIDTH > 32)) begin : g_bad_width
        $error("mult_pipe_top: WIDTH must be even and within 8..32");
    end
    if ((APPROX_K % 2 != 0) || (APPROX_K < 0) || (APPROX_K > WIDTH - 2)) begin : g_bad_k
        $error("mult_pipe_top: APPROX_K must be even and within 0..WIDTH-2");
    end
    if ((STAGES < 2) || (STAGES > 4)) begin : g_bad_stages
        $error("mult_pipe_top: STAGES must be within 2..4");
    end

    logic [STAGES:1]     vld;
    logic [STAGES:1]     adv;
    logic [WIDTH-1:0]    x_q;
    logic [WIDTH-1:0]    y_q;
    logic                mode_q [1:STAGES];
    logic [TAG_W-1:0]    tag_q  [1:STAGES];
    logic [2*WIDTH-1:0]  prod_q [2:STAGES];
    logic [2*WIDTH-1:0]  prod;

    booth_r4_mult #(
        .WIDTH    (WIDTH),
        .APPROX_K (APPROX_K)
    ) u_mult (
        .x      (x_q),
        .y      (y_q),
        .approx (mode_q[1] == MODE_APPROX),
        .p      (prod)
    );

    // Advance ripples back from the output; never depends on in_valid
    always_comb begin
        adv = '0;
        adv[STAGES] = !vld[STAGES] || out_ready;
        for (int i = STAGES - 1; i >= 1; i--) begin
            adv[i] = !vld[i] || adv[i+1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            x_q <= '0;
            y_q <= '0;
            for (int i = 1; i <= STAGES; i++) begin
                mode_q[i] <= 1'b0;
                tag_q[i]  <= '0;
            end
            for (int i = 2; i <= STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else begin
            if (adv[1]) begin
                vld[1] <= in_valid;
                if (in_valid) begin
                    x_q       <= x;
                    y_q       <= y;
                    mode_q[1] <= in_mode;
                    tag_q[1]  <= in_tag;
                end
            end
            if (adv[2]) begin
                vld[2] <= vld[1];
                if (vld[1]) begin
                    prod_q[2] <= prod;
                    mode_q[2] <= mode_q[1];
                    tag_q[2]  <= tag_q[1];
                end
            end
            for (int i = 3; i <= STAGES; i++) begin
                if (adv[i]) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1]) begin
                        prod_q[i] <= prod_q[i-1];
                        mode_q[i] <= mode_q[i-1];
                        tag_q[i]  <= tag_q[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = adv[1];
    assign out_valid = vld[STAGES];
    assign p_out     = prod_q[STAGES];
    assign out_mode  = mode_q[STAGES];
    assign out_tag   = tag_q[STAGES];

endmodule

// File: tb/tb_mult_pipe_top.sv
// Scoreboard bench: two instances (APPROX_K=4 and APPROX_K=0) share stimulus;
// expected results come from plain integer arithmetic.
module tb_mult_pipe_top;

    localparam int W  = 16;
    localparam int S  = 2;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  x = '0;
    logic [W-1:0]  y = '0;
    logic          in_mode = 1'b0;
    logic [TW-1:0] in_tag = '0;
    logic          out_ready = 1'b1;

    logic          in_ready, out_valid, out_mode;
    logic [2*W-1:0] p_out;
    logic [TW-1:0] out_tag;
    logic          in_ready0, out_valid0, out_mode0;
    logic [2*W-1:0] p_out0;
    logic [TW-1:0] out_tag0;

    mult_pipe_top #(.WIDTH(W), .STAGES(S), .APPROX_K(4), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .p_out(p_out),
        .out_mode(out_mode), .out_tag(out_tag)
    );

    mult_pipe_top #(.WIDTH(W), .STAGES(S), .APPROX_K(0), .TAG_W(TW)) dut_k0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .x(x), .y(y), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid0), .out_ready(out_ready), .p_out(p_out0),
        .out_mode(out_mode0), .out_tag(out_tag0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   p4;
        logic [31:0]   p0;
        logic          m;
        logic [TW-1:0] t;
        logic [31:0]   gold;
        bit            has_gold;
        bit            chk_lat;
        int            acc_cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          acc_cnt = 0;
    int          or_mode = 1;
    logic [31:0] cur_gold = '0;
    bit          cur_has_gold = 0;
    bit          cur_chk_lat = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // x * (y - sext(y[k-1:0])) in approximate mode, x * y otherwise
    function automatic logic [31:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic m, input int k);
        longint xa, yb, lo;
        xa = longint'($signed(a));
        yb = longint'($signed(b));
        if (m && k > 0) begin
            lo = longint'(b) & ((longint'(1) << k) - 1);
            if (lo >= (longint'(1) << (k - 1))) lo = lo - (longint'(1) << k);
            yb = yb - lo;
        end
        return 32'(xa * yb);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (or_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(3) != 0);
            endcase
        end
    end

    // Monitor: pops and compares on every output handshake, pushes on acceptance
    logic [31:0]   prev_p = '0;
    logic          prev_m = 1'b0;
    logic [TW-1:0] prev_t = '0;
    bit            prev_stall = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check(out_valid, "hold_valid", longint'(out_valid), 1);
                check(p_out == prev_p && out_mode == prev_m && out_tag == prev_t, "hold_stable",
                      longint'(p_out), longint'(prev_p));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check(!out_valid, "unexpected_output", longint'(out_tag), -1);
                end else begin
                    e = sb.pop_front();
                    check(p_out == e.p4, "p_out", longint'(p_out), longint'(e.p4));
                    check(out_mode == e.m, "out_mode", longint'(out_mode), longint'(e.m));
                    check(out_tag == e.t, "out_tag", longint'(out_tag), longint'(e.t));
                    check(out_valid0 && p_out0 == e.p0 && out_tag0 == e.t, "p_out_k0",
                          longint'(p_out0), longint'(e.p0));
                    if (e.has_gold) check(p_out == e.gold, "golden", longint'(p_out), longint'(e.gold));
                    if (e.chk_lat) check(cyc - e.acc_cyc == S, "latency", longint'(cyc - e.acc_cyc), S);
                end
            end
            if (in_valid && in_ready) begin
                e.p4       = ref_mult(x, y, in_mode, 4);
                e.p0       = ref_mult(x, y, in_mode, 0);
                e.m        = in_mode;
                e.t        = in_tag;
                e.gold     = cur_gold;
                e.has_gold = cur_has_gold;
                e.chk_lat  = cur_chk_lat;
                e.acc_cyc  = cyc;
                sb.push_back(e);
                acc_cnt++;
                check(in_ready0, "in_ready_k0", longint'(in_ready0), 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_p     = p_out;
            prev_m     = out_mode;
            prev_t     = out_tag;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                        input logic [TW-1:0] t, input bit hg, input logic [31:0] g, input bit lat);
        int w = 0;
        x = a; y = b; in_mode = m; in_tag = t; in_valid = 1'b1;
        cur_has_gold = hg; cur_gold = g; cur_chk_lat = lat;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 500) begin
                check(in_ready, "accept_timeout", longint'(in_ready), 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cur_has_gold = 0;
        cur_chk_lat = 0;
    endtask

    task automatic drain();
        int w = 0;
        or_mode = 1;
        while (sb.size() != 0 && w < 200) begin
            @(posedge clk);
            w++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(sb.size() == 0, "drain_empty", longint'(sb.size()), 0);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(7))
            0:       return 16'h8000;
            1:       return 16'h7FFF;
            2:       return 16'h0000;
            3:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int base;
        #2;
        check(!out_valid, "reset_out_valid", longint'(out_valid), 0);
        check(in_ready, "reset_in_ready", longint'(in_ready), 1);
        check(p_out == '0 && out_tag == '0 && !out_mode, "reset_outputs", longint'(p_out), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        or_mode = 1;
        out_ready = 1'b1;

        // Directed exact, sign and approximate cases
        send(16'h7FFF, 16'h7FFF, 1'b0, 4'd3, 1, 32'h3FFF0001, 1);
        idle();
        drain();
        send(16'hFFFF, 16'h0001, 1'b0, 4'd1, 1, 32'hFFFFFFFF, 1);
        send(16'h8000, 16'h8000, 1'b0, 4'd2, 1, 32'h40000000, 1);
        send(16'd100,  16'h0013, 1'b1, 4'd4, 1, 32'd1600, 1);
        send(16'd3,    16'h000F, 1'b1, 4'd5, 1, 32'd48, 1);
        send(16'd100,  16'h0013, 1'b0, 4'd6, 1, 32'd1900, 1);
        send(16'd3,    16'h000F, 1'b0, 4'd7, 1, 32'd45, 1);
        idle();
        drain();

        // Backpressure: stall output while streaming tags 0..5
        or_mode = 0;
        out_ready = 1'b0;
        base = acc_cnt;
        fork
            begin
                for (int t = 0; t < 6; t++) begin
                    send(pick(), pick(), 1'($urandom_range(1)), 4'(t), 0, '0, 0);
                end
                idle();
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                check(acc_cnt - base == S, "bp_accepted", longint'(acc_cnt - base), S);
                check(!in_ready, "bp_in_ready_low", longint'(in_ready), 0);
                check(out_valid, "bp_out_valid", longint'(out_valid), 1);
                or_mode = 1;
                out_ready = 1'b1;
                #1;
                check(in_ready, "bp_release_ready", longint'(in_ready), 1);
            end
        join
        drain();

        // Reset with two transactions in flight
        or_mode = 0;
        out_ready = 1'b0;
        send(16'h1234, 16'h5678, 1'b0, 4'd1, 0, '0, 0);
        send(16'h0FED, 16'hCBA9, 1'b1, 4'd2, 0, '0, 0);
        idle();
        check(out_valid, "pre_rst_full", longint'(out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check(!out_valid, "rst_async_valid", longint'(out_valid), 0);
        check(p_out == '0, "rst_async_p_out", longint'(p_out), 0);
        check(out_tag == '0 && !out_mode, "rst_async_tag", longint'(out_tag), 0);
        check(in_ready, "rst_in_ready", longint'(in_ready), 1);
        sb.delete();
        @(posedge clk);
        #1;
        check(!out_valid && p_out == '0, "rst_held", longint'(p_out), 0);
        rst_n = 1'b1;
        or_mode = 1;
        out_ready = 1'b1;
        send(16'hFFFE, 16'h0003, 1'b0, 4'd9, 1, 32'hFFFFFFFA, 1);
        idle();
        drain();

        // Random traffic with random valid/ready
        or_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            send(pick(), pick(), 1'($urandom_range(1)), 4'($urandom_range(15)), 0, '0, 0);
        end
        idle();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired at %0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule
